// File: rtl/io_pkg.sv
// ============================================================================
// io_pkg
// Address map, CSR bit positions and send-FSM state type for io_reg_bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_pkg;

  localparam logic [5:0] ADDR_GPIO_OUT  = 6'd0;
  localparam logic [5:0] ADDR_GPIO_IN   = 6'd1;
  localparam logic [5:0] ADDR_IRQ_MASK  = 6'd2;
  localparam logic [5:0] ADDR_IRQ_STAT  = 6'd3;
  localparam int unsigned ADDR_CHAN_BASE = 4;

  localparam logic [1:0] CHAN_TXDATA = 2'd0;
  localparam logic [1:0] CHAN_RXDATA = 2'd1;
  localparam logic [1:0] CHAN_CSR    = 2'd2;

  localparam int unsigned CSR_SEND       = 0;
  localparam int unsigned CSR_TX_BUSY    = 1;
  localparam int unsigned CSR_RX_AVAIL   = 2;
  localparam int unsigned CSR_RX_OVERRUN = 3;
  localparam int unsigned CSR_TX_DONE    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } send_state_t;

  // Word address of register 'off' within channel 'ch'.
  function automatic logic [5:0] chan_addr(input int unsigned ch, input logic [1:0] off);
    return 6'(ADDR_CHAN_BASE + 4 * ch + 32'(off));
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_uart_chan.sv
// ============================================================================
// io_uart_chan
// One UART channel: TXDATA/RXDATA/CSR registers, send handshake FSM, RX capture.
// Optional feature macro: IO_IRQ_EN (tracks tx_done in CSR bit 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_uart_chan
  import io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wen,
  input  logic       csr_wen,
  input  logic       rx_rd,
  input  logic [7:0] wdata,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       send,
  output logic [7:0] rx_byte,
  output logic [4:0] csr
);

  send_state_t r_state;
  send_state_t w_state_next;
  logic        w_send;
  logic        w_done_set;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_rx_byte;
  logic        r_rx_avail;
  logic        r_rx_overrun;
  logic        r_tx_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_send       = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      IDLE: if (csr_wen && wdata[CSR_SEND]) w_state_next = REQ;
      REQ: begin
        w_send = 1'b1;
        if (tx_busy) w_state_next = BUSY;
      end
      BUSY: if (!tx_busy) begin
        w_state_next = IDLE;
        w_done_set   = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data    <= '0;
      r_rx_byte    <= '0;
      r_rx_avail   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (tx_wen && r_state == IDLE) r_tx_data <= wdata;
      // A byte arriving with a read keeps avail set; it is not an overrun.
      if (rx_valid) begin
        r_rx_byte  <= rx_data;
        r_rx_avail <= 1'b1;
      end else if (rx_rd) begin
        r_rx_avail <= 1'b0;
      end
      if (rx_valid && r_rx_avail && !rx_rd)               r_rx_overrun <= 1'b1;
      else if (csr_wen && wdata[CSR_RX_OVERRUN])          r_rx_overrun <= 1'b0;
    end
  end

`ifdef IO_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)                                   r_tx_done <= 1'b0;
    else if (w_done_set)                       r_tx_done <= 1'b1;
    else if (csr_wen && wdata[CSR_TX_DONE])    r_tx_done <= 1'b0;
  end
`else
  logic w_unused_done;
  assign w_unused_done = w_done_set;
  assign r_tx_done     = 1'b0;
`endif

  assign tx_data = r_tx_data;
  assign send    = w_send;
  assign rx_byte = r_rx_byte;
  assign csr     = {r_tx_done, r_rx_overrun, r_rx_avail, tx_busy, (r_state != IDLE)};

endmodule

`default_nettype wire

// File: rtl/io_reg_bank.sv
// ============================================================================
// io_reg_bank
// IO register bank: GPIO out/in, NUM_UART UART channels, registered read port.
// Optional feature macro: IO_IRQ_EN (IRQ_MASK/IRQ_STAT registers and irq output).
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_reg_bank
  import io_pkg::*;
#(
  parameter int NUM_UART = 2,
  parameter int GPIO_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [15:0]           waddr,
  input  logic [31:0]           wdata,
  input  logic                  ren,
  input  logic [15:0]           raddr,
  output logic [31:0]           rdata,
  output logic [GPIO_W-1:0]     gpio_out,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [8*NUM_UART-1:0] uart_tx_data,
  output logic [NUM_UART-1:0]   uart_send,
  input  logic [NUM_UART-1:0]   uart_tx_busy,
  input  logic [8*NUM_UART-1:0] uart_rx_data,
  input  logic [NUM_UART-1:0]   uart_rx_valid,
  output logic                  irq
);

  logic [5:0]        w_wa;
  logic [5:0]        w_ra;
  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_gpio_sync1;
  logic [GPIO_W-1:0] r_gpio_sync2;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rd_val;
  logic [4:0]        w_csr     [NUM_UART];
  logic [7:0]        w_rx_byte [NUM_UART];

  assign w_wa = waddr[5:0];
  assign w_ra = raddr[5:0];

  logic w_unused;
  assign w_unused = &{1'b0, waddr[15:6], raddr[15:6], wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_out   <= '0;
      r_gpio_sync1 <= '0;
      r_gpio_sync2 <= '0;
    end else begin
      if (wen && w_wa == ADDR_GPIO_OUT) r_gpio_out <= wdata[GPIO_W-1:0];
      r_gpio_sync1 <= gpio_in;
      r_gpio_sync2 <= r_gpio_sync1;
    end
  end

  generate
    for (genvar c = 0; c < NUM_UART; c++) begin : g_chan
      io_uart_chan u_chan (
        .clk      (clk),
        .rst      (rst),
        .tx_wen   (wen && w_wa == chan_addr(c, CHAN_TXDATA)),
        .csr_wen  (wen && w_wa == chan_addr(c, CHAN_CSR)),
        .rx_rd    (ren && w_ra == chan_addr(c, CHAN_RXDATA)),
        .wdata    (wdata[7:0]),
        .tx_busy  (uart_tx_busy[c]),
        .rx_data  (uart_rx_data[8*c +: 8]),
        .rx_valid (uart_rx_valid[c]),
        .tx_data  (uart_tx_data[8*c +: 8]),
        .send     (uart_send[c]),
        .rx_byte  (w_rx_byte[c]),
        .csr      (w_csr[c])
      );
    end
  endgenerate

`ifdef IO_IRQ_EN
  logic [15:0] r_irq_mask;
  logic [15:0] w_irq_stat;
  logic        r_irq;

  always_comb begin
    w_irq_stat = '0;
    for (int c = 0; c < NUM_UART; c++) begin
      w_irq_stat[c]     = w_csr[c][CSR_RX_AVAIL];
      w_irq_stat[8 + c] = w_csr[c][CSR_TX_DONE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (wen && w_wa == ADDR_IRQ_MASK) r_irq_mask <= wdata[15:0];
      r_irq <= |(w_irq_stat & r_irq_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_ra)
      ADDR_GPIO_OUT: w_rd_val = 32'(r_gpio_out);
      ADDR_GPIO_IN:  w_rd_val = 32'(r_gpio_sync2);
`ifdef IO_IRQ_EN
      ADDR_IRQ_MASK: w_rd_val = 32'(r_irq_mask);
      ADDR_IRQ_STAT: w_rd_val = 32'(w_irq_stat);
`endif
      default:       w_rd_val = '0;
    endcase
    for (int c = 0; c < NUM_UART; c++) begin
      if (w_ra == chan_addr(c, CHAN_TXDATA)) w_rd_val = 32'(uart_tx_data[8*c +: 8]);
      if (w_ra == chan_addr(c, CHAN_RXDATA)) w_rd_val = 32'(w_rx_byte[c]);
      if (w_ra == chan_addr(c, CHAN_CSR))    w_rd_val = 32'(w_csr[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      r_rdata <= '0;
    else if (ren) r_rdata <= w_rd_val;
  end

  assign rdata    = r_rdata;
  assign gpio_out = r_gpio_out;

endmodule

`default_nettype wire
